// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM state codes,
// the default boot address and the layout of one buffered fetch entry.
package ifetch_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_HOLD       = 2'd1;
  localparam logic [1:0] ST_HOLD_REDIR = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

  localparam int unsigned ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, data} entries. The head is
// read straight from the storage array at the registered read pointer, so
// there is no look-ahead path from push to the head. Flush empties the
// queue and overrides any push or pop in the same cycle.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH      = ENTRY_W,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_data_o,
  output logic                  head_valid_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;

  // Occupancy: a simultaneous push and pop leaves the count untouched.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; flush rewinds both pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Entry storage, cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_data_o  = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: generates sequential fetch addresses into
// the instruction cache, buffers returned words with their PC, and handles
// redirects. While the cache stalls a request the address and read strobe
// are frozen, because the cache fills its line from the live address; a
// redirect arriving then is parked in pend_pc until the stall clears.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          DEPTH_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        dbus_read,
  output logic [31:0] dbus_rdaddr,
  input  logic [31:0] dbus_rddata,
  input  logic        dbus_rdstall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  logic [1:0]          state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         pend_pc_q, pend_pc_d;
  logic [31:0]         redir_pc;
  logic                read_req;
  logic                accept;
  logic                push;
  logic                flush;
  logic                pop;
  logic [DEPTH_LOG2:0] count;
  fetch_entry_t        push_entry;
  fetch_entry_t        head_entry;
  logic                unused_redir_low;

  assign redir_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_redir_low = ^redirect_pc[1:0];

  // Fetch FSM: decides the next PC, the pending redirect target and whether
  // the word returned this cycle is kept. The read strobe looks only at the
  // registered count, so a push can never land on a full queue.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push       = 1'b0;
    flush      = redirect_valid;
    read_req   = (state_q == ST_RUN) ? (count < FULL_COUNT) : 1'b1;
    accept     = read_req & ~dbus_rdstall;

    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          if (read_req && dbus_rdstall) begin
            state_d   = ST_HOLD_REDIR;
            pend_pc_d = redir_pc;
          end else begin
            fetch_pc_d = redir_pc;
          end
        end else if (read_req && dbus_rdstall) begin
          state_d = ST_HOLD;
        end else if (accept) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          if (accept) begin
            fetch_pc_d = redir_pc;
            state_d    = ST_RUN;
          end else begin
            pend_pc_d = redir_pc;
            state_d   = ST_HOLD_REDIR;
          end
        end else if (accept) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_RUN;
        end
      end
      ST_HOLD_REDIR: begin
        if (accept) begin
          fetch_pc_d = redirect_valid ? redir_pc : pend_pc_q;
          state_d    = ST_RUN;
        end else if (redirect_valid) begin
          pend_pc_d = redir_pc;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM and PC registers, all returned to their boot values by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_VECTOR;
      pend_pc_q  <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign dbus_read   = read_req & ~rst;
  assign dbus_rdaddr = fetch_pc_q;

  assign push_entry.pc   = fetch_pc_q;
  assign push_entry.data = dbus_rddata;
  assign pop             = inst_valid & inst_ready;

  fetch_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_data_o  (head_entry),
    .head_valid_o (inst_valid),
    .count_o      (count)
  );

  assign inst_pc   = head_entry.pc;
  assign inst_data = head_entry.data;

endmodule
